// File: rtl/square_plotter.sv
// Expands one (x, y, colour) request into SIZE x SIZE raster-order pixel writes, one per clock, then a one-cycle DONE.
// Optional SQUARE_BORDER_EN build paints the perimeter with BORDER_COLOUR; requests wait on req_ready while busy.
module square_plotter #(
  parameter int         SIZE          = 4,
  parameter logic [2:0] BORDER_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       square_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] LAST = 4'(SIZE - 1);

  logic [1:0] state;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] col;
  logic [3:0] off_x;
  logic [3:0] off_y;
  logic       row_end;
  logic [2:0] pix_colour;

  assign row_end = (off_x == LAST);

`ifdef SQUARE_BORDER_EN
  logic perimeter;
  assign perimeter  = (off_x == 4'd0) || (off_x == LAST) || (off_y == 4'd0) || (off_y == LAST);
  // Erase (colour 000) must stay fully black, so the border only applies to real colours.
  assign pix_colour = ((col != 3'b000) && perimeter) ? BORDER_COLOUR : col;
`else
  logic unused_border;
  assign unused_border = ^BORDER_COLOUR;
  assign pix_colour    = col;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      base_x <= 8'd0;
      base_y <= 7'd0;
      col    <= 3'd0;
      off_x  <= 4'd0;
      off_y  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is unconditionally high here once reset is low.
          if (req_valid) begin
            base_x <= req_x;
            base_y <= req_y;
            col    <= req_colour;
            off_x  <= 4'd0;
            off_y  <= 4'd0;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (row_end) begin
            off_x <= 4'd0;
            off_y <= off_y + 4'd1;
            if (off_y == LAST) state <= DONE;
          end else begin
            off_x <= off_x + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    busy        = 1'b0;
    square_done = 1'b0;
    vga_plot    = 1'b0;
    vga_x       = 8'd0;
    vga_y       = 7'd0;
    vga_colour  = 3'd0;
    if (!reset) begin
      req_ready   = (state == IDLE);
      busy        = (state == DRAW) || (state == DONE);
      square_done = (state == DONE);
      if (state == DRAW) begin
        vga_plot   = 1'b1;
        vga_x      = base_x + {4'd0, off_x};
        vga_y      = base_y + {3'd0, off_y};
        vga_colour = pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_square_plotter.sv
// Directed bench for square_plotter: SIZE=4 main instance plus a SIZE=1 instance for the minimum-size case.
module tb_square_plotter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_valid1;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;

  logic       req_ready, vga_plot, busy, square_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  logic       req_ready1, vga_plot1, busy1, square_done1;
  logic [7:0] vga_x1;
  logic [6:0] vga_y1;
  logic [2:0] vga_colour1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  square_plotter #(.SIZE(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .square_done(square_done)
  );

  square_plotter #(.SIZE(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .vga_x(vga_x1), .vga_y(vga_y1), .vga_colour(vga_colour1), .vga_plot(vga_plot1),
    .busy(busy1), .square_done(square_done1)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [7:0] last_x;
    logic [6:0] last_y;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_col(input logic [2:0] c, input int ox, input int oy);
`ifdef SQUARE_BORDER_EN
    if (c != 3'b000 && (ox == 0 || ox == 3 || oy == 0 || oy == 3)) return 3'b111;
`endif
    return c;
  endfunction

  // Called in the cycle right after the accepting edge; ends in the cycle where req_ready is back.
  task automatic draw_check(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c,
                            output logic [7:0] lx, output logic [6:0] ly);
    logic [7:0] ex;
    logic [6:0] ey;
    lx = 8'd0;
    ly = 7'd0;
    for (int oy = 0; oy < 4; oy++) begin
      for (int ox = 0; ox < 4; ox++) begin
        ex = bx + 8'(ox);
        ey = by + 7'(oy);
        chk("plot", vga_plot, 1);
        chk("pix_x", vga_x, ex);
        chk("pix_y", vga_y, ey);
        chk("pix_colour", vga_colour, exp_col(c, ox, oy));
        chk("done_during_draw", square_done, 0);
        chk("ready_during_draw", req_ready, 0);
        lx = vga_x;
        ly = vga_y;
        tick();
      end
    end
    chk("done_pulse", square_done, 1);
    chk("done_plot", vga_plot, 0);
    chk("done_ready", req_ready, 0);
    chk("done_busy", busy, 1);
    chk("done_x", vga_x, 0);
    tick();
    chk("ready_after", req_ready, 1);
    chk("done_after", square_done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [7:0] lx;
    logic [6:0] ly;
    int done_seen;

    tbl[0] = '{x: 8'd254, y: 7'd126, c: 3'b011, last_x: 8'd1,   last_y: 7'd1};
    tbl[1] = '{x: 8'd0,   y: 7'd0,   c: 3'b000, last_x: 8'd3,   last_y: 7'd3};
    tbl[2] = '{x: 8'd100, y: 7'd120, c: 3'b111, last_x: 8'd103, last_y: 7'd123};
    tbl[3] = '{x: 8'd252, y: 7'd124, c: 3'b101, last_x: 8'd255, last_y: 7'd127};

    reset = 1'b1; req_valid = 1'b0; req_valid1 = 1'b0;
    req_x = 8'd0; req_y = 7'd0; req_colour = 3'd0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", square_done, 0);
    chk("rst_x", vga_x, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", req_ready, 1);

    // Basic square, with the next request held on req_valid throughout.
    req_valid = 1'b1; req_x = 8'd10; req_y = 7'd53; req_colour = 3'b100;
    tick();
    req_x = 8'd40; req_y = 7'd64; req_colour = 3'b001;
    draw_check(8'd10, 7'd53, 3'b100, lx, ly);
    chk("sq1_last_x", lx, 13);
    chk("sq1_last_y", ly, 56);
    tick();
    req_valid = 1'b0;
    draw_check(8'd40, 7'd64, 3'b001, lx, ly);

    // Table of squares, including wrap-around and erase.
    for (int i = 0; i < 4; i++) begin
      req_x = tbl[i].x; req_y = tbl[i].y; req_colour = tbl[i].c;
      req_valid = 1'b1;
      chk("tbl_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      draw_check(tbl[i].x, tbl[i].y, tbl[i].c, lx, ly);
      chk("tbl_last_x", lx, tbl[i].last_x);
      chk("tbl_last_y", ly, tbl[i].last_y);
    end

    // Reset after 5 pixels abandons the square with no done pulse.
    req_x = 8'd20; req_y = 7'd30; req_colour = 3'b010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_plot", vga_plot, 1);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_plot", vga_plot, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_plot", vga_plot, 0);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (square_done || vga_plot) done_seen++;
      tick();
    end
    chk("no_done_after_rst", done_seen, 0);

    // Minimum size instance.
    req_x = 8'd5; req_y = 7'd5; req_colour = 3'b110; req_valid1 = 1'b1;
    chk("s1_ready", req_ready1, 1);
    tick();
    req_valid1 = 1'b0;
    chk("s1_plot", vga_plot1, 1);
    chk("s1_x", vga_x1, 5);
    chk("s1_y", vga_y1, 5);
`ifdef SQUARE_BORDER_EN
    chk("s1_colour", vga_colour1, 3'b111);
`else
    chk("s1_colour", vga_colour1, 3'b110);
`endif
    chk("s1_done_early", square_done1, 0);
    tick();
    chk("s1_done", square_done1, 1);
    chk("s1_done_plot", vga_plot1, 0);
    chk("s1_done_ready", req_ready1, 0);
    tick();
    chk("s1_ready_again", req_ready1, 1);
    chk("s1_done_clear", square_done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_plotter.md
Name: square_plotter

Overview:
- Downstream stage of the square selector; consumes one square request (start x, start y, colour) at a time.
- Expands each request into SIZE x SIZE individual pixel writes for the VGA adapter, one pixel per clock.
- Pulses square_done when a square finishes; the top level uses this pulse to advance the square selector.
- Provides a valid/ready handshake so requests are never lost or overlapped.

Parameters:
- SIZE, 4, side length of a square in pixels; legal range 1..16.
- BORDER_COLOUR, 3'b111, perimeter colour; used only when SQUARE_BORDER_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present on req_x/req_y/req_colour.
- req_ready  out  1  block can accept a request this cycle.
- req_x  in  8  square start x.
- req_y  in  7  square start y.
- req_colour  in  3  square colour; 3'b000 erases.
- vga_x  out  8  pixel x to the VGA adapter.
- vga_y  out  7  pixel y to the VGA adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write enable.
- busy  out  1  high while in DRAW or DONE.
- square_done  out  1  one-cycle pulse after the last pixel of a square.

Behaviour:
- States: IDLE, DRAW, DONE. Registers: base_x[7:0], base_y[6:0], col[2:0], off_x[3:0], off_y[3:0].
- Reset (sampled at a rising edge):
  - Next state is IDLE; all registers clear to 0.
  - While reset is high: req_ready=0, vga_plot=0, square_done=0, busy=0, vga_x/vga_y/vga_colour=0.
- req_ready = (state==IDLE) && !reset.
- Acceptance:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - On acceptance, req_x/req_y/req_colour are latched, off_x=off_y=0, and the next state is DRAW.
  - req_valid while not ready is ignored: no latch, no side effect.
- DRAW, combinational outputs from registers:
  - vga_plot=1.
  - vga_x = base_x + off_x, truncated to 8 bits (mod 256).
  - vga_y = base_y + off_y, truncated to 7 bits (mod 128). No clipping.
  - vga_colour = col.
- DRAW, raster order (x fastest):
  - If off_x==SIZE-1: off_x resets to 0 and off_y increments.
  - Otherwise: off_x increments.
  - The pixel with off_x==SIZE-1 and off_y==SIZE-1 is the last; the next state after it is DONE.
- DONE (exactly one cycle):
  - vga_plot=0, square_done=1, busy=1, req_ready=0.
  - Next state is IDLE.
- IDLE and DONE outputs: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
- Timing:
  - If acceptance is at edge N, pixels appear in cycles N+1 .. N+SIZE².
  - square_done is high in cycle N+SIZE²+1.
  - req_ready is high again from cycle N+SIZE²+2.
  - Maximum throughput is one square per SIZE²+2 cycles.
- Reset mid-operation: at the reset edge, go to IDLE; the partial square is abandoned and no square_done pulse is issued.
- SIZE=1: DRAW lasts one cycle, then DONE.

Optional Feature:
- Macro: SQUARE_BORDER_EN.
- Defined:
  - A pixel is on the perimeter when off_x or off_y is 0 or SIZE-1.
  - If col != 3'b000, perimeter pixels use BORDER_COLOUR and interior pixels use col.
  - If col == 3'b000, every pixel is 3'b000, so erase stays a full black square.
- Not defined: every pixel uses col; BORDER_COLOUR is unused.
- Timing is identical in both builds.

Test Plan:
1. Basic square:
   - Stimulus: reset, then a request (x=10, y=53, colour=100) accepted at edge N.
   - Required: 16 plot cycles visiting (10,53),(11,53),(12,53),(13,53),(10,54),…,(13,56), all colour 100.
   - Required: square_done=1 only in cycle N+17; req_ready=1 from N+18.
2. Busy hold-off:
   - Stimulus: req_valid held high with new data (x=40, y=64, colour=001) throughout square 1.
   - Required: data is ignored until ready; the second square is accepted at N+18 and its first pixel is (40,64).
3. Wrap-around:
   - Stimulus: request x=254, y=126.
   - Required: x sequence 254,255,0,1 per row; y sequence 126,127,0,1; no clipping.
4. Reset mid-draw:
   - Stimulus: reset asserted after 5 pixels.
   - Required: vga_plot=0 from the next cycle; no square_done pulse; req_ready=1 the cycle after reset deasserts.
5. Border build:
   - Stimulus: SQUARE_BORDER_EN defined, request colour=001.
   - Required: 12 perimeter pixels are 111; interior pixels (1,1),(2,1),(1,2),(2,2) are 001.
   - Stimulus: request colour=000. Required: all 16 pixels are 000.
6. Minimum size:
   - Stimulus: SIZE=1, request (5,5,110).
   - Required: a single plot at (5,5) with colour 110; square_done the next cycle; ready the cycle after that.
